// File: rtl/pipe_addsub_pkg.sv
// Shared constants and helpers for the segmented add/subtract pipeline.
// Op-select encodings, saturation limits and the configuration legality test.
package pipe_addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Upper bound on WIDTH; the saturation helpers return this many bits.
    localparam int MAX_W = 256;

    function automatic logic [MAX_W-1:0] sat_max(input int w);
        logic [MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w - 1) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [MAX_W-1:0] sat_min(input int w);
        logic [MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i == w - 1) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic bit cfg_ok(input int w, input int s);
        return (s >= 1) && (s <= w) && (w <= MAX_W) && ((w % s) == 0);
    endfunction

endpackage

// File: rtl/pipe_addsub_sat_add_seg.sv
// Purpose: one SW-bit carry segment of the pipelined adder.
// Latency: combinational.
// Backpressure: none; the enclosing pipeline stage owns the handshake.
module add_seg #(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a_i,
    input  logic [SW-1:0] b_i,
    input  logic          cin_i,
    output logic [SW-1:0] sum_o,
    output logic          cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{SW{1'b0}}, cin_i};

endmodule

// File: rtl/pipe_addsub_sat.sv
// Purpose: carry-segmented, pipelined signed add/sub with optional saturation and overflow count.
// Latency: SEGS cycles from accept to out_valid, one op per cycle.
// Backpressure: whole pipeline freezes while out_valid && !out_ready; accepts need locked.
module pipe_addsub_sat
    import pipe_addsub_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int SEGS     = 4,
    parameter bit SATURATE = 1'b0,
    parameter int OFCNT_W  = 16
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               locked,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   sum,
    output logic               OF,
    output logic               co,
    output logic [OFCNT_W-1:0] of_count
);

    localparam int SW = WIDTH / SEGS;
    localparam int L  = SEGS - 1;

    localparam logic [MAX_W-1:0] SMAX_F = sat_max(WIDTH);
    localparam logic [MAX_W-1:0] SMIN_F = sat_min(WIDTH);
    localparam logic [WIDTH-1:0] SMAX   = SMAX_F[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SMIN   = SMIN_F[WIDTH-1:0];

    if (!cfg_ok(WIDTH, SEGS)) begin : g_cfg_err
        $fatal(1, "pipe_addsub_sat: WIDTH must be a multiple of SEGS, 1 <= SEGS <= WIDTH");
    end

    logic adv;

    // Inputs seen by stage k: the ports for k = 0, otherwise the register of stage k-1.
    logic [WIDTH-1:0] st_a   [SEGS];
    logic [WIDTH-1:0] st_bx  [SEGS];
    logic [WIDTH-1:0] st_res [SEGS];
    logic             st_c   [SEGS];
    logic             st_sub [SEGS];
    logic             st_vld [SEGS];
    logic [SW-1:0]    seg_s  [SEGS];
    logic             seg_co [SEGS];

    logic               out_vld_q;
    logic [WIDTH-1:0]   sum_q;
    logic               of_q;
    logic               co_q;
    logic [OFCNT_W-1:0] cnt_q;

    assign adv      = !out_vld_q || out_ready;
    assign in_ready = locked && adv;

    // Subtraction is folded in up front as a + ~b + 1.
    assign st_a[0]   = a;
    assign st_bx[0]  = (sub == OP_SUB) ? ~b : b;
    assign st_res[0] = '0;
    assign st_c[0]   = sub;
    assign st_sub[0] = sub;
    assign st_vld[0] = in_valid && in_ready;

    for (genvar k = 0; k < SEGS; k++) begin : g_stage
        add_seg #(.SW(SW)) u_seg (
            .a_i    (st_a[k][k*SW +: SW]),
            .b_i    (st_bx[k][k*SW +: SW]),
            .cin_i  (st_c[k]),
            .sum_o  (seg_s[k]),
            .cout_o (seg_co[k])
        );

        if (k < L) begin : g_reg
            logic [WIDTH-1:0] a_q, bx_q, res_q, res_d;
            logic             c_q, sub_q, vld_q;

            always_comb begin
                res_d              = st_res[k];
                res_d[k*SW +: SW]  = seg_s[k];
            end

            always_ff @(posedge refclk) begin
                if (rst) begin
                    vld_q <= 1'b0;
                end else if (adv) begin
                    vld_q <= st_vld[k];
                end
            end

            always_ff @(posedge refclk) begin
                if (adv) begin
                    a_q   <= st_a[k];
                    bx_q  <= st_bx[k];
                    res_q <= res_d;
                    c_q   <= seg_co[k];
                    sub_q <= st_sub[k];
                end
            end

            assign st_a[k+1]   = a_q;
            assign st_bx[k+1]  = bx_q;
            assign st_res[k+1] = res_q;
            assign st_c[k+1]   = c_q;
            assign st_sub[k+1] = sub_q;
            assign st_vld[k+1] = vld_q;
        end
    end

    logic [WIDTH-1:0] raw, sum_d;
    logic             a_msb, b_msb, r_msb, of_d;

    always_comb begin
        raw             = st_res[L];
        raw[L*SW +: SW] = seg_s[L];
        a_msb           = st_a[L][WIDTH-1];
        b_msb           = st_bx[L][WIDTH-1] ^ st_sub[L];
        r_msb           = raw[WIDTH-1];
        if (st_sub[L] == OP_ADD) begin
            of_d = (a_msb == b_msb) && (r_msb != a_msb);
        end else begin
            of_d = (a_msb != b_msb) && (r_msb != a_msb);
        end
        sum_d = raw;
        if (SATURATE && of_d) begin
            sum_d = a_msb ? SMIN : SMAX;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            out_vld_q <= 1'b0;
            sum_q     <= '0;
            of_q      <= 1'b0;
            co_q      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (adv) begin
                out_vld_q <= st_vld[L];
                sum_q     <= sum_d;
                of_q      <= of_d;
                co_q      <= seg_co[L];
            end
            if (out_vld_q && out_ready && of_q && (cnt_q != {OFCNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign out_valid = out_vld_q;
    assign sum       = sum_q;
    assign OF        = of_q;
    assign co        = co_q;
    assign of_count  = cnt_q;

endmodule

// File: tb/tb_pipe_addsub_sat.sv
// Bench: wrap and saturating instances driven in lockstep, checked against a scoreboard.
// The saturating instance uses a 3-bit overflow counter so its ceiling is reachable.
module tb_pipe_addsub_sat;

    logic        refclk = 1'b0;
    logic        rst = 1'b1, locked = 1'b1, in_valid = 1'b0, sub = 1'b0, out_ready = 1'b1;
    logic [31:0] a = '0, b = '0;

    logic        in_ready0, in_ready1, ov0, ov1, of0, of1, co0, co1;
    logic [31:0] sum0, sum1;
    logic [15:0] ofc0;
    logic [2:0]  ofc1;

    always #5 refclk = ~refclk;

    pipe_addsub_sat #(.WIDTH(32), .SEGS(4), .SATURATE(1'b0), .OFCNT_W(16)) u_wrap (
        .refclk(refclk), .rst(rst), .locked(locked), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .sub(sub), .out_valid(ov0), .out_ready(out_ready),
        .sum(sum0), .OF(of0), .co(co0), .of_count(ofc0)
    );

    pipe_addsub_sat #(.WIDTH(32), .SEGS(4), .SATURATE(1'b1), .OFCNT_W(3)) u_sat (
        .refclk(refclk), .rst(rst), .locked(locked), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .sub(sub), .out_valid(ov1), .out_ready(out_ready),
        .sum(sum1), .OF(of1), .co(co1), .of_count(ofc1)
    );

    typedef struct {
        logic [31:0] s0;
        logic [31:0] s1;
        logic        of;
        logic        co;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0, n_bad = 0, cyc = 0, n_acc = 0;
    int   cnt0 = 0, cnt1 = 0;
    bit   lat_mode = 1'b0, prev_stall = 1'b0, after_rst = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [31:0] ia, input logic [31:0] ib, input logic isub);
        exp_t        e;
        longint      sa, sbv, r;
        logic [63:0] rr;
        logic [32:0] ucarry;
        sa     = longint'($signed(ia));
        sbv    = longint'($signed(ib));
        r      = isub ? (sa - sbv) : (sa + sbv);
        rr     = r;
        ucarry = {1'b0, ia} + {1'b0, ib};
        e.of   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        e.co   = isub ? (ia >= ib) : ucarry[32];
        e.s0   = rr[31:0];
        e.s1   = e.of ? ((r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000) : rr[31:0];
        e.acc  = cyc;
        return e;
    endfunction

    task automatic step(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                        input logic isub, input logic ordy, input logic lk, input logic irst);
        logic exp_rdy0, exp_rdy1;
        exp_t h;
        @(negedge refclk);
        in_valid = iv; a = ia; b = ib; sub = isub; out_ready = ordy; locked = lk; rst = irst;
        #1;
        if (irst) begin
            sbq.delete();
            cnt0 = 0; cnt1 = 0;
            prev_stall = 1'b0;
            after_rst  = 1'b1;
        end else begin
            if (after_rst) begin
                chk("rst_vld0", ov0, 0);
                chk("rst_vld1", ov1, 0);
                chk("rst_sum", sum0, 0);
                chk("rst_of", of0, 0);
                chk("rst_co", co0, 0);
                chk("rst_ofc0", ofc0, 0);
                chk("rst_ofc1", ofc1, 0);
                after_rst = 1'b0;
            end
            exp_rdy0 = lk && (!ov0 || ordy);
            exp_rdy1 = lk && (!ov1 || ordy);
            chk("in_ready0", in_ready0, exp_rdy0);
            chk("in_ready1", in_ready1, exp_rdy1);
            chk("of_count0", ofc0, cnt0);
            chk("of_count1", ofc1, cnt1);
            if (prev_stall) chk("hold_vld", ov0, 1);
            if (sbq.size() == 0) begin
                chk("no_stale0", ov0, 0);
                chk("no_stale1", ov1, 0);
            end else if (ov0) begin
                h = sbq[0];
                chk("vld1", ov1, 1);
                chk("sum_wrap", sum0, h.s0);
                chk("sum_sat", sum1, h.s1);
                chk("of_wrap", of0, h.of);
                chk("of_sat", of1, h.of);
                chk("co_wrap", co0, h.co);
                chk("co_sat", co1, h.co);
                if (ordy) begin
                    if (lat_mode) chk("latency", cyc - h.acc, 4);
                    if (h.of) begin
                        cnt0 = (cnt0 == 65535) ? cnt0 : cnt0 + 1;
                        cnt1 = (cnt1 == 7) ? cnt1 : cnt1 + 1;
                    end
                    void'(sbq.pop_front());
                end
            end
            if (iv && exp_rdy0) begin
                sbq.push_back(model(ia, ib, isub));
                n_acc++;
            end
            prev_stall = ov0 && !ordy;
        end
        @(posedge refclk);
        cyc++;
    endtask

    task automatic drain(input logic lk);
        for (int i = 0; i < 40 && sbq.size() != 0; i++) step(1'b0, '0, '0, 1'b0, 1'b1, lk, 1'b0);
        chk("drain", sbq.size(), 0);
    endtask

    task automatic send1(input logic [31:0] ia, input logic [31:0] ib, input logic isub);
        step(1'b1, ia, ib, isub, 1'b1, 1'b1, 1'b0);
        drain(1'b1);
    endtask

    initial begin
        int target;
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Isolated directed ops with latency checking.
        lat_mode = 1'b1;
        send1(32'd10, 32'd20, 1'b0);
        send1(32'h7FFF_FFFF, 32'd1, 1'b0);
        send1(32'h8000_0000, 32'd1, 1'b1);
        send1(32'd5, 32'd5, 1'b1);
        send1(32'h00FF_FFFF, 32'd1, 1'b0);
        send1(32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        send1(32'd3, 32'd7, 1'b1);
        lat_mode = 1'b0;

        // Back-to-back random ops with a randomly stalling sink.
        target = n_acc + 8;
        for (int i = 0; i < 100 && n_acc < target; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if ((i % 3) == 0) ra = {1'b0, ra[30:0]} | 32'h7000_0000;
            step(1'b1, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end
        chk("rand_accepts", n_acc, target);
        for (int i = 0; i < 60 && sbq.size() != 0; i++)
            step(1'b0, '0, '0, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        drain(1'b1);

        // Drive the 3-bit counter past its ceiling.
        for (int i = 0; i < 10; i++) step(1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        drain(1'b1);

        // Lock drops with two ops in flight.
        step(1'b1, 32'd100, 32'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'd200, 32'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, $urandom, $urandom, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("locked_drain", sbq.size(), 0);

        // Reset with three ops in flight, then confirm nothing stale emerges.
        step(1'b1, 32'h7FFF_FFFF, 32'd5, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'd1, 32'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'd3, 32'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'd9, 32'd9, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        lat_mode = 1'b1;
        send1(32'h8000_0000, 32'h8000_0000, 1'b0);
        lat_mode = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
